// File: rtl/ahb_master_arbiter_pkg.sv
// Shared types and constants for the two-master AHB-Lite arbiter.
package ahb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef logic master_id_t;

    localparam master_id_t MASTER_0 = 1'b0;
    localparam master_id_t MASTER_1 = 1'b1;

    // An address phase after which the grant may move: the owner is idle, or
    // it is issuing a SINGLE that is accepted on this edge.
    function automatic logic is_switch_point(htrans_t trans, logic [2:0] burst);
        return (trans == HTRANS_IDLE) ||
               ((trans == HTRANS_NONSEQ) && (burst == HBURST_SINGLE));
    endfunction

endpackage

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter. Grants the address phase to one master at a
// time and tracks data-phase ownership separately so pipelined transfers are
// never mixed. The non-granted master is stalled with hready low.
module ahb_master_arbiter
    import ahb_master_arbiter_pkg::*;
#(
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter bit          RR_ENABLE      = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    // master 0 (data)
    input  logic [31:0] m0_haddr_i,
    input  logic [2:0]  m0_hburst_i,
    input  logic [2:0]  m0_hsize_i,
    input  logic [1:0]  m0_htrans_i,
    input  logic        m0_hwrite_i,
    input  logic [31:0] m0_hwdata_i,
    output logic [31:0] m0_hrdata_o,
    output logic        m0_hready_o,
    output logic        m0_hresp_o,
    // master 1 (instruction fetch)
    input  logic [31:0] m1_haddr_i,
    input  logic [2:0]  m1_hburst_i,
    input  logic [2:0]  m1_hsize_i,
    input  logic [1:0]  m1_htrans_i,
    input  logic        m1_hwrite_i,
    input  logic [31:0] m1_hwdata_i,
    output logic [31:0] m1_hrdata_o,
    output logic        m1_hready_o,
    output logic        m1_hresp_o,
    // shared link to the decode mux
    output logic [31:0] bus_haddr_o,
    output logic [2:0]  bus_hburst_o,
    output logic [2:0]  bus_hsize_o,
    output logic [1:0]  bus_htrans_o,
    output logic        bus_hwrite_o,
    output logic [31:0] bus_hwdata_o,
    input  logic [31:0] bus_hrdata_i,
    input  logic        bus_hready_i,
    input  logic        bus_hresp_i,
    output logic        grant
);

    localparam master_id_t DEF_ID = master_id_t'(DEFAULT_MASTER[0]);

    master_id_t grant_q, grant_d;
    master_id_t dp_owner_q, dp_owner_d;
    logic       dp_active_q, dp_active_d;

    htrans_t    g_htrans;
    logic [2:0] g_hburst;
    master_id_t other_id;
    logic       other_req;

    assign g_htrans  = htrans_t'(grant_q ? m1_htrans_i : m0_htrans_i);
    assign g_hburst  = grant_q ? m1_hburst_i : m0_hburst_i;
    assign other_id  = ~grant_q;
    // BUSY counts as a request: anything other than IDLE.
    assign other_req = (other_id ? m1_htrans_i : m0_htrans_i) != 2'(HTRANS_IDLE);

    // Ownership registers; advance only when the bus accepts the current phase.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            grant_q     <= DEF_ID;
            dp_owner_q  <= DEF_ID;
            dp_active_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            grant_q     <= grant_d;
            dp_owner_q  <= dp_owner_d;
            dp_active_q <= dp_active_d;
        end
    end

    // Next-state: data phase follows the accepted address phase; grant moves
    // only at a switch point and only towards a requesting master.
    always_comb begin
        // NOTE: hold values assigned first so no path leaves a latch behind.
        grant_d     = grant_q;
        dp_owner_d  = dp_owner_q;
        dp_active_d = dp_active_q;
        if (bus_hready_i) begin
            dp_active_d = (g_htrans == HTRANS_NONSEQ) || (g_htrans == HTRANS_SEQ);
            dp_owner_d  = grant_q;
            if (is_switch_point(g_htrans, g_hburst) && other_req &&
                (RR_ENABLE || (other_id == MASTER_0))) begin
                grant_d = other_id;
            end
        end
    end

    // Bus muxing: address phase from the granted master, write data from the
    // data-phase owner, read data broadcast.
    always_comb begin
        bus_haddr_o  = grant_q ? m1_haddr_i  : m0_haddr_i;
        bus_hburst_o = grant_q ? m1_hburst_i : m0_hburst_i;
        bus_hsize_o  = grant_q ? m1_hsize_i  : m0_hsize_i;
        bus_hwrite_o = grant_q ? m1_hwrite_i : m0_hwrite_i;
        bus_hwdata_o = dp_owner_q ? m1_hwdata_i : m0_hwdata_i;
        // NOTE: nRST gates the transfer type directly so the bus goes IDLE the
        // instant reset asserts, not at the next clock edge.
        bus_htrans_o = nRST ? 2'(g_htrans) : 2'(HTRANS_IDLE);
        m0_hrdata_o  = bus_hrdata_i;
        m1_hrdata_o  = bus_hrdata_i;
    end

    // A master sees hready while it owns the address phase or its data phase
    // is in flight; hresp only belongs to the data-phase owner.
    assign m0_hready_o = nRST && bus_hready_i &&
                         ((grant_q == MASTER_0) || (dp_active_q && (dp_owner_q == MASTER_0)));
    assign m1_hready_o = nRST && bus_hready_i &&
                         ((grant_q == MASTER_1) || (dp_active_q && (dp_owner_q == MASTER_1)));
    assign m0_hresp_o  = nRST && bus_hresp_i && dp_active_q && (dp_owner_q == MASTER_0);
    assign m1_hresp_o  = nRST && bus_hresp_i && dp_active_q && (dp_owner_q == MASTER_1);

    assign grant = grant_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: two instances (round-robin default 0, fixed
// priority default 1) share stimulus and are compared every cycle against a
// reference model of the ownership rules.
module tb_ahb_master_arbiter;

    typedef struct packed {
        logic [31:0] haddr;
        logic [2:0]  hburst;
        logic [2:0]  hsize;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] hwdata;
    } mst_t;

    typedef struct packed {
        logic        grant;
        logic [31:0] haddr;
        logic [2:0]  hburst;
        logic [2:0]  hsize;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] hwdata;
        logic [31:0] hrdata0;
        logic        hready0;
        logic        hresp0;
        logic [31:0] hrdata1;
        logic        hready1;
        logic        hresp1;
    } out_t;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001, B_INCR4 = 3'b011;

    logic        CLK;
    logic        nRST;
    mst_t        m [2];
    logic [31:0] bus_hrdata;
    logic        bus_hready;
    logic        bus_hresp;

    logic        o_grant   [2];
    logic [31:0] o_haddr   [2];
    logic [2:0]  o_hburst  [2];
    logic [2:0]  o_hsize   [2];
    logic [1:0]  o_htrans  [2];
    logic        o_hwrite  [2];
    logic [31:0] o_hwdata  [2];
    logic [31:0] o_hrdata0 [2];
    logic        o_hready0 [2];
    logic        o_hresp0  [2];
    logic [31:0] o_hrdata1 [2];
    logic        o_hready1 [2];
    logic        o_hresp1  [2];
    out_t        obs [2];

    // reference model state, one entry per instance
    int grant_m  [2];
    int dp_own_m [2];
    bit dp_act_m [2];
    int def_m    [2] = '{0, 1};
    bit rr_m     [2] = '{1'b1, 1'b0};

    int checks = 0;
    int errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    ahb_master_arbiter #(.DEFAULT_MASTER(0), .RR_ENABLE(1'b1)) dut_rr (
        .CLK(CLK), .nRST(nRST),
        .m0_haddr_i(m[0].haddr), .m0_hburst_i(m[0].hburst), .m0_hsize_i(m[0].hsize),
        .m0_htrans_i(m[0].htrans), .m0_hwrite_i(m[0].hwrite), .m0_hwdata_i(m[0].hwdata),
        .m0_hrdata_o(o_hrdata0[0]), .m0_hready_o(o_hready0[0]), .m0_hresp_o(o_hresp0[0]),
        .m1_haddr_i(m[1].haddr), .m1_hburst_i(m[1].hburst), .m1_hsize_i(m[1].hsize),
        .m1_htrans_i(m[1].htrans), .m1_hwrite_i(m[1].hwrite), .m1_hwdata_i(m[1].hwdata),
        .m1_hrdata_o(o_hrdata1[0]), .m1_hready_o(o_hready1[0]), .m1_hresp_o(o_hresp1[0]),
        .bus_haddr_o(o_haddr[0]), .bus_hburst_o(o_hburst[0]), .bus_hsize_o(o_hsize[0]),
        .bus_htrans_o(o_htrans[0]), .bus_hwrite_o(o_hwrite[0]), .bus_hwdata_o(o_hwdata[0]),
        .bus_hrdata_i(bus_hrdata), .bus_hready_i(bus_hready), .bus_hresp_i(bus_hresp),
        .grant(o_grant[0])
    );

    ahb_master_arbiter #(.DEFAULT_MASTER(1), .RR_ENABLE(1'b0)) dut_fp (
        .CLK(CLK), .nRST(nRST),
        .m0_haddr_i(m[0].haddr), .m0_hburst_i(m[0].hburst), .m0_hsize_i(m[0].hsize),
        .m0_htrans_i(m[0].htrans), .m0_hwrite_i(m[0].hwrite), .m0_hwdata_i(m[0].hwdata),
        .m0_hrdata_o(o_hrdata0[1]), .m0_hready_o(o_hready0[1]), .m0_hresp_o(o_hresp0[1]),
        .m1_haddr_i(m[1].haddr), .m1_hburst_i(m[1].hburst), .m1_hsize_i(m[1].hsize),
        .m1_htrans_i(m[1].htrans), .m1_hwrite_i(m[1].hwrite), .m1_hwdata_i(m[1].hwdata),
        .m1_hrdata_o(o_hrdata1[1]), .m1_hready_o(o_hready1[1]), .m1_hresp_o(o_hresp1[1]),
        .bus_haddr_o(o_haddr[1]), .bus_hburst_o(o_hburst[1]), .bus_hsize_o(o_hsize[1]),
        .bus_htrans_o(o_htrans[1]), .bus_hwrite_o(o_hwrite[1]), .bus_hwdata_o(o_hwdata[1]),
        .bus_hrdata_i(bus_hrdata), .bus_hready_i(bus_hready), .bus_hresp_i(bus_hresp),
        .grant(o_grant[1])
    );

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            obs[k] = {o_grant[k], o_haddr[k], o_hburst[k], o_hsize[k], o_htrans[k],
                      o_hwrite[k], o_hwdata[k], o_hrdata0[k], o_hready0[k], o_hresp0[k],
                      o_hrdata1[k], o_hready1[k], o_hresp1[k]};
        end
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            grant_m[k]  = def_m[k];
            dp_own_m[k] = def_m[k];
            dp_act_m[k] = 1'b0;
        end
    endtask

    // Ownership rules applied at a rising edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!nRST) begin
                grant_m[k]  = def_m[k];
                dp_own_m[k] = def_m[k];
                dp_act_m[k] = 1'b0;
            end else if (bus_hready) begin
                int g = grant_m[k];
                int o = 1 - g;
                bit sw = (m[g].htrans == T_IDLE) ||
                         (m[g].htrans == T_NSEQ && m[g].hburst == B_SINGLE);
                dp_act_m[k] = (m[g].htrans == T_NSEQ) || (m[g].htrans == T_SEQ);
                dp_own_m[k] = g;
                if (sw && m[o].htrans != T_IDLE && (rr_m[k] || o == 0))
                    grant_m[k] = o;
            end
        end
    endtask

    function automatic out_t exp_out(int k);
        out_t e;
        int g = grant_m[k];
        int d = dp_own_m[k];
        e.grant   = g[0];
        e.haddr   = m[g].haddr;
        e.hburst  = m[g].hburst;
        e.hsize   = m[g].hsize;
        e.hwrite  = m[g].hwrite;
        e.htrans  = nRST ? m[g].htrans : T_IDLE;
        e.hwdata  = m[d].hwdata;
        e.hrdata0 = bus_hrdata;
        e.hrdata1 = bus_hrdata;
        e.hready0 = nRST && bus_hready && (g == 0 || (dp_act_m[k] && d == 0));
        e.hready1 = nRST && bus_hready && (g == 1 || (dp_act_m[k] && d == 1));
        e.hresp0  = nRST && bus_hresp && dp_act_m[k] && d == 0;
        e.hresp1  = nRST && bus_hresp && dp_act_m[k] && d == 1;
        return e;
    endfunction

    // Advance one clock: model follows the edge, inputs change 1 ns later.
    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic set_m(int i, logic [1:0] t, logic [2:0] b, logic [31:0] a, logic w, logic [31:0] d);
        m[i].htrans = t;
        m[i].hburst = b;
        m[i].haddr  = a;
        m[i].hsize  = 3'b010;
        m[i].hwrite = w;
        m[i].hwdata = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_m(0, T_NSEQ, B_SINGLE, 32'h0000_0100, 1'b1, 32'h1111_0000);
        set_m(1, T_NSEQ, B_INCR4, 32'h0000_0200, 1'b0, 32'h2222_0000);
        bus_hready = 1'b1;
        bus_hresp  = 1'b1;
        bus_hrdata = 32'h5A5A_5A5A;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin
                    errors++;
                    $display("FAIL reset[%0d] cyc=%0d got=%h exp=%h", k, c, obs[k], exp_out(k));
                end
                checks++;
                if ({o_htrans[k], o_hready0[k], o_hready1[k], o_hresp0[k], o_hresp1[k], o_grant[k]} !==
                    {T_IDLE, 4'b0000, def_m[k][0]}) begin
                    errors++;
                    $display("FAIL reset_quiet[%0d] htrans=%b rdy=%b%b resp=%b%b grant=%b",
                             k, o_htrans[k], o_hready0[k], o_hready1[k], o_hresp0[k], o_hresp1[k], o_grant[k]);
                end
            end
            tick();
        end
        bus_hresp = 1'b0;
    endtask

    task automatic test_single_read();
        nRST = 1'b1;
        set_m(0, T_NSEQ, B_SINGLE, 32'h0000_1000, 1'b0, 32'h0);
        set_m(1, T_IDLE, B_SINGLE, 32'h0000_0000, 1'b0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            if (c == 1) begin
                m[0].htrans = T_IDLE;
                bus_hrdata  = 32'hCAFE_F00D;
            end
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin
                    errors++;
                    $display("FAIL single_read[%0d] cyc=%0d got=%h exp=%h", k, c, obs[k], exp_out(k));
                end
            end
            checks++;
            if (c == 0 && {o_grant[0], o_haddr[0], o_htrans[0], o_hready1[0], o_grant[1]} !==
                          {1'b0, 32'h0000_1000, T_NSEQ, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL single_addr grant=%b haddr=%h htrans=%b m1rdy=%b fpgrant=%b (want 0 1000 10 0 1)",
                         o_grant[0], o_haddr[0], o_htrans[0], o_hready1[0], o_grant[1]);
            end
            if (c == 1 && {o_hready0[0], o_hrdata0[0], o_hready1[0]} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
                errors++;
                $display("FAIL single_data m0rdy=%b hrdata=%h m1rdy=%b (want 1 cafef00d 0)",
                         o_hready0[0], o_hrdata0[0], o_hready1[0]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int g0 = grant_m[0];
        set_m(0, T_NSEQ, B_SINGLE, 32'h0000_4000, 1'b1, 32'hAAAA_0000);
        set_m(1, T_NSEQ, B_SINGLE, 32'h0000_5000, 1'b0, 32'hBBBB_0000);
        for (int c = 0; c < 8; c++) begin
            logic exp_g = 1'((g0 + c) % 2);
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin
                    errors++;
                    $display("FAIL b2b[%0d] cyc=%0d got=%h exp=%h", k, c, obs[k], exp_out(k));
                end
            end
            checks++;
            if ({o_grant[0], o_haddr[0]} !== {exp_g, exp_g ? 32'h0000_5000 : 32'h0000_4000}) begin
                errors++;
                $display("FAIL b2b_alternate cyc=%0d grant=%b haddr=%h want_grant=%b", c, o_grant[0], o_haddr[0], exp_g);
            end
            tick();
        end
    endtask

    task automatic test_incr4_hold();
        logic [1:0] beat_t [5] = '{T_NSEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE};
        set_m(0, T_IDLE, B_SINGLE, 32'h0000_1100, 1'b0, 32'h0);
        set_m(1, T_NSEQ, B_INCR4, 32'h0000_2000, 1'b0, 32'h0);
        for (int n = 0; n < 8 && grant_m[0] != 1; n++) begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin
                    errors++;
                    $display("FAIL incr4_wait[%0d] got=%h exp=%h", k, obs[k], exp_out(k));
                end
            end
            tick();
        end
        checks++;
        if (o_grant[0] !== 1'b1) begin
            errors++;
            $display("FAIL incr4_grant_wait grant=%b want=1", o_grant[0]);
        end
        for (int b = 0; b < 5; b++) begin
            m[1].htrans = beat_t[b];
            m[1].haddr  = 32'h0000_2000 + 32'(4 * b);
            m[0].htrans = (b >= 1) ? T_NSEQ : T_IDLE;
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin
                    errors++;
                    $display("FAIL incr4[%0d] beat=%0d got=%h exp=%h", k, b, obs[k], exp_out(k));
                end
            end
            checks++;
            if (o_grant[0] !== 1'b1) begin
                errors++;
                $display("FAIL incr4_hold beat=%0d grant=%b want=1", b, o_grant[0]);
            end
            tick();
        end
        @(negedge CLK);
        checks++;
        if ({o_grant[0], o_haddr[0], o_htrans[0]} !== {1'b0, 32'h0000_1100, T_NSEQ}) begin
            errors++;
            $display("FAIL incr4_handover grant=%b haddr=%h htrans=%b (want 0 1100 10)",
                     o_grant[0], o_haddr[0], o_htrans[0]);
        end
        tick();
        m[0].htrans = T_IDLE;
    endtask

    task automatic test_wait_states();
        set_m(0, T_NSEQ, B_SINGLE, 32'h0000_1200, 1'b1, 32'h0);
        set_m(1, T_NSEQ, B_SINGLE, 32'h0000_2200, 1'b0, 32'h0);
        bus_hready = 1'b1;
        for (int n = 0; n < 8 && grant_m[0] != 0; n++) begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin
                    errors++;
                    $display("FAIL ws_wait[%0d] got=%h exp=%h", k, obs[k], exp_out(k));
                end
            end
            tick();
        end
        tick();  // m0's write address accepted; grant moves to m1
        for (int c = 0; c < 3; c++) begin
            m[0].htrans = T_IDLE;
            m[0].hwdata = 32'hD00D_0001;
            bus_hready  = (c == 2);
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin
                    errors++;
                    $display("FAIL ws[%0d] cyc=%0d got=%h exp=%h", k, c, obs[k], exp_out(k));
                end
            end
            checks++;
            if ({o_hready0[0], o_hwdata[0], o_grant[0], o_haddr[0]} !==
                {(c == 2), 32'hD00D_0001, 1'b1, 32'h0000_2200}) begin
                errors++;
                $display("FAIL ws_stall cyc=%0d m0rdy=%b hwdata=%h grant=%b haddr=%h",
                         c, o_hready0[0], o_hwdata[0], o_grant[0], o_haddr[0]);
            end
            tick();
        end
        m[1].htrans = T_IDLE;
    endtask

    task automatic test_error();
        set_m(0, T_IDLE, B_SINGLE, 32'h0000_1300, 1'b0, 32'h0);
        set_m(1, T_NSEQ, B_SINGLE, 32'h0000_3000, 1'b1, 32'h0);
        bus_hready = 1'b1;
        bus_hresp  = 1'b0;
        for (int n = 0; n < 8 && grant_m[0] != 1; n++) begin
            @(negedge CLK);
            tick();
        end
        tick();  // m1's write address accepted
        for (int c = 0; c < 2; c++) begin
            m[1].htrans = T_IDLE;
            m[1].hwdata = 32'hE0E0_0003;
            m[0].htrans = T_NSEQ;
            bus_hresp   = 1'b1;
            bus_hready  = (c == 1);
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin
                    errors++;
                    $display("FAIL error[%0d] cyc=%0d got=%h exp=%h", k, c, obs[k], exp_out(k));
                end
            end
            checks++;
            if ({o_hresp1[0], o_hready1[0], o_hresp0[0]} !== {1'b1, (c == 1), 1'b0}) begin
                errors++;
                $display("FAIL error_resp cyc=%0d m1resp=%b m1rdy=%b m0resp=%b", c, o_hresp1[0], o_hready1[0], o_hresp0[0]);
            end
            tick();
        end
        bus_hresp   = 1'b0;
        m[0].htrans = T_IDLE;
    endtask

    task automatic test_async_reset();
        set_m(0, T_NSEQ, B_INCR, 32'h0000_6000, 1'b1, 32'h6666_0000);
        set_m(1, T_SEQ, B_INCR4, 32'h0000_7000, 1'b0, 32'h7777_0000);
        bus_hready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            tick();
        end
        #1;
        nRST = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_out(k)) begin
                errors++;
                $display("FAIL async_rst[%0d] got=%h exp=%h", k, obs[k], exp_out(k));
            end
            checks++;
            if ({o_grant[k], o_htrans[k], o_hready0[k], o_hready1[k]} !== {def_m[k][0], T_IDLE, 2'b00}) begin
                errors++;
                $display("FAIL async_rst_state[%0d] grant=%b htrans=%b rdy=%b%b", k, o_grant[k], o_htrans[k], o_hready0[k], o_hready1[k]);
            end
        end
        checks++;
        if (dut_rr.dp_active_q !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_dp_active got=%b want=0", dut_rr.dp_active_q);
        end
        @(negedge CLK);
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                m[i].htrans = 2'($urandom_range(0, 3));
                m[i].hburst = ($urandom_range(0, 1) == 0) ? B_SINGLE : 3'($urandom_range(1, 7));
                m[i].haddr  = $urandom;
                m[i].hsize  = 3'($urandom_range(0, 2));
                m[i].hwrite = 1'($urandom_range(0, 1));
                m[i].hwdata = $urandom;
            end
            bus_hrdata = $urandom;
            bus_hready = ($urandom_range(0, 3) != 0);
            bus_hresp  = ($urandom_range(0, 5) == 0);
            nRST       = ($urandom_range(0, 49) != 0);
            if (!nRST) model_reset();
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_out(k)) begin
                    errors++;
                    $display("FAIL random[%0d] cyc=%0d got=%h exp=%h", k, c, obs[k], exp_out(k));
                end
            end
            tick();
        end
    endtask

    initial begin
        nRST       = 1'b0;
        bus_hready = 1'b1;
        bus_hresp  = 1'b0;
        bus_hrdata = 32'h0;
        set_m(0, T_IDLE, B_SINGLE, 32'h0, 1'b0, 32'h0);
        set_m(1, T_IDLE, B_SINGLE, 32'h0, 1'b0, 32'h0);
        model_reset();
        #1;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_incr4_hold();
        test_wait_states();
        test_error();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
